// File: rtl/rom_access_arbiter.sv
// -----------------------------------------------------------------------------
// rom_access_arbiter
//
// Purpose:
//   Shares the single combinational instruction ROM between two requesters:
//   instruction fetch (IF, port 0) and data-side constant/literal reads
//   (DM, port 1). One access is serviced at a time through a fixed
//   IDLE -> ACCESS -> RESP cadence (at most one access every three cycles).
//   The byte address is range-checked against the text segment before it is
//   driven to the ROM, and the returned word is registered.
//
// Configuration:
//   ROM_ARB_FIXED_PRIO_EN  - when defined, IF always wins a tie (no
//                            last-owner state). When undefined (default),
//                            ties are resolved round-robin.
//
// Ports:
//   clk          in   1    system clock, rising edge
//   reset        in   1    asynchronous, active-low reset
//   if_req_i     in   1    IF request, held with if_addr_i until if_rvalid_o
//   if_addr_i    in   DW   IF byte address
//   dm_req_i     in   1    DM request, same protocol as IF
//   dm_addr_i    in   DW   DM byte address
//   if_gnt_o     out  1    one-cycle pulse: IF request accepted
//   dm_gnt_o     out  1    one-cycle pulse: DM request accepted
//   if_rvalid_o  out  1    one-cycle pulse: rdata_o/err_o belong to IF
//   dm_rvalid_o  out  1    one-cycle pulse: rdata_o/err_o belong to DM
//   rdata_o      out  DW   registered read word (0 on error)
//   err_o        out  1    access was out of range or misaligned
//   busy_o       out  1    high in ACCESS and RESP
//   rom_addr_o   out  DW   byte address to the ROM
//   rom_data_i   in   DW   combinational ROM read data
// -----------------------------------------------------------------------------
module rom_access_arbiter #(
    parameter int unsigned                DATA_WIDTH   = 32,
    parameter int unsigned                MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0]      BASE_ADDR    = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    input  logic                  dm_req_i,
    input  logic [DATA_WIDTH-1:0] dm_addr_i,
    output logic                  if_gnt_o,
    output logic                  dm_gnt_o,
    output logic                  if_rvalid_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

    logic [1:0]            r_state;
    logic                  r_owner;
    logic                  r_addr_ok;
    logic [DATA_WIDTH-1:0] r_rom_addr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_any_req;
    logic                  w_pick_dm;
    logic [DATA_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_offset;
    logic                  w_aligned;
    logic                  w_above_base;
    logic                  w_in_depth;
    logic                  w_addr_ok;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    assign w_any_req = if_req_i | dm_req_i;

`ifdef ROM_ARB_FIXED_PRIO_EN
    // IF always wins a tie; DM is only picked when IF is idle.
    assign w_pick_dm = dm_req_i & ~if_req_i;
`else
    logic r_last_owner;

    // On a tie the port that did not win last time is picked.
    assign w_pick_dm = dm_req_i & (~if_req_i | (r_last_owner == OWNER_IF));

    // Reset value DM makes the first tie after reset go to IF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_owner <= OWNER_DM;
        end else if ((r_state == IDLE) && w_any_req) begin
            r_last_owner <= w_pick_dm;
        end
    end
`endif

    assign w_sel_addr = w_pick_dm ? dm_addr_i : if_addr_i;

    // ------------------------------------------------------------------
    // Range check. The base comparison gates the subtraction result, so a
    // wrapped offset for addresses below the base can never validate.
    // ------------------------------------------------------------------
    assign w_aligned    = (w_sel_addr[1:0] == 2'b00);
    assign w_above_base = (w_sel_addr >= BASE_ADDR);
    assign w_offset     = w_sel_addr - BASE_ADDR;
    assign w_in_depth   = ((w_offset >> 2) < DEPTH_W);
    assign w_addr_ok    = w_aligned & w_above_base & w_in_depth;

    // ------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------
    // The ROM address register is loaded in IDLE so that it is already
    // presented during ACCESS; invalid requests park it at the base so the
    // ROM never sees an out-of-range index. It holds in IDLE and RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_owner    <= OWNER_IF;
            r_addr_ok  <= 1'b0;
            r_rom_addr <= BASE_ADDR;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= ACCESS;
                        r_owner    <= w_pick_dm;
                        r_addr_ok  <= w_addr_ok;
                        r_rom_addr <= w_addr_ok ? w_sel_addr : BASE_ADDR;
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                    r_rdata <= r_addr_ok ? rom_data_i : '0;
                    r_err   <= ~r_addr_ok;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign if_gnt_o    = (r_state == ACCESS) & (r_owner == OWNER_IF);
    assign dm_gnt_o    = (r_state == ACCESS) & (r_owner == OWNER_DM);
    assign if_rvalid_o = (r_state == RESP)   & (r_owner == OWNER_IF);
    assign dm_rvalid_o = (r_state == RESP)   & (r_owner == OWNER_DM);
    assign busy_o      = (r_state != IDLE);
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;
    assign rom_addr_o  = r_rom_addr;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_access_arbiter
//
// Purpose:
//   Self-checking bench for rom_access_arbiter. A behavioural ROM answers
//   rom_addr_o; expected responses are queued as requests are driven and
//   popped by a monitor whenever an rvalid pulse appears.
//   Honours ROM_ARB_FIXED_PRIO_EN for the tie-break expectations.
// -----------------------------------------------------------------------------
module tb_rom_access_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        dm_req_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic        if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o, busy_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] rom_off;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    rom_access_arbiter #(
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (DEPTH),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .dm_req_i    (dm_req_i),
        .dm_addr_i   (dm_addr_i),
        .if_gnt_o    (if_gnt_o),
        .dm_gnt_o    (dm_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .dm_rvalid_o (dm_rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i)
    );

    // Behavioural ROM: word 2 fixed, others tagged with their index.
    function automatic logic [31:0] rom_word(int unsigned idx);
        if (idx == 2) return 32'h2009_0005;
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    assign rom_off    = rom_addr_o - BASE;
    assign rom_data_i = rom_word(int'(rom_off[7:2]));

    // Independent reference for the address check, in 64-bit arithmetic.
    function automatic bit addr_ok(logic [31:0] a);
        longint unsigned la, lb;
        la = 64'(a);
        lb = 64'(BASE);
        if ((la % 4) != 0) return 1'b0;
        if (la < lb) return 1'b0;
        return ((la - lb) / 4) < DEPTH;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        bit          port;   // 0 = IF, 1 = DM
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push_exp(bit port, logic [31:0] a);
        exp_t e;
        logic [31:0] off;
        e.port = port;
        e.err  = !addr_ok(a);
        off    = a - BASE;
        e.data = e.err ? 32'h0 : rom_word(int'(off >> 2));
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (if_rvalid_o || dm_rvalid_o) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rvalid", 32'(if_rvalid_o) | 32'(dm_rvalid_o), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_owner", 32'({if_rvalid_o, dm_rvalid_o}), mon_e.port ? 32'h1 : 32'h2);
                check("sb_rdata", rdata_o, mon_e.data);
                check("sb_err", 32'(err_o), 32'(mon_e.err));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(bit port, bit req, logic [31:0] a);
        if (port) begin
            dm_req_i  = req;
            dm_addr_i = a;
        end else begin
            if_req_i  = req;
            if_addr_i = a;
        end
    endtask

    // One isolated request; checks grant, ROM address, rvalid timing,
    // return to IDLE and rdata hold. Optionally drops req right after grant.
    task automatic single(bit port, logic [31:0] a, bit drop_early, string tag);
        logic [31:0] exp_ra;
        logic [31:0] exp_rd;
        logic [31:0] off;
        exp_ra = addr_ok(a) ? a : BASE;
        off    = a - BASE;
        exp_rd = addr_ok(a) ? rom_word(int'(off >> 2)) : 32'h0;
        push_exp(port, a);
        @(posedge clk); #1;
        drive(port, 1'b1, a);
        @(posedge clk); @(negedge clk);
        check({tag, "_gnt"}, 32'({if_gnt_o, dm_gnt_o}), port ? 32'h1 : 32'h2);
        check({tag, "_romaddr"}, rom_addr_o, exp_ra);
        if (drop_early) drive(port, 1'b0, 32'hDEAD_BEEF);
        @(posedge clk); @(negedge clk);
        check({tag, "_rvalid"}, 32'({if_rvalid_o, dm_rvalid_o}), port ? 32'h1 : 32'h2);
        @(posedge clk); #1;
        drive(port, 1'b0, a);
        @(negedge clk);
        check({tag, "_idle"}, 32'({busy_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}), 32'h0);
        check({tag, "_hold"}, rdata_o, exp_rd);
    endtask

    task automatic wait_gnt(output bit got, output int unsigned n);
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            got = if_gnt_o | dm_gnt_o;
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit          got;
        int unsigned n;
        bit          exp_dm;

        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 32'({if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, err_o, busy_o}), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_romaddr", rom_addr_o, BASE);
        @(posedge clk); #1 reset = 1'b1;

        single(1'b0, 32'h0040_0008, 1'b0, "if_w2");
        single(1'b1, 32'h0040_0100, 1'b0, "dm_oor");
        single(1'b1, 32'h003F_FFFC, 1'b0, "dm_below");
        single(1'b1, 32'h0040_0002, 1'b0, "dm_misal");
        single(1'b1, 32'h0040_00FC, 1'b0, "dm_w63");
        single(1'b1, 32'h0040_0024, 1'b0, "dm_w9");
        single(1'b0, 32'h0040_0010, 1'b1, "if_drop");

        // Both requests held from reset: alternation (or IF only).
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'h0040_0000);
        drive(1'b1, 1'b1, 32'h0040_0004);
        @(posedge clk); #1 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            exp_dm = 1'b0;
`else
            exp_dm = (k % 2) == 1;
`endif
            push_exp(exp_dm, exp_dm ? 32'h0040_0004 : 32'h0040_0000);
            wait_gnt(got, n);
            check("rr_gnt_seen", 32'(got), 32'h1);
            check("rr_gnt_owner", 32'({if_gnt_o, dm_gnt_o}), exp_dm ? 32'h1 : 32'h2);
            if (k > 0) check("rr_cadence", n, 32'd3);
        end
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        repeat (4) @(negedge clk);

        // Reset during ACCESS of an IF read.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h0040_0008);
        @(posedge clk); @(negedge clk);
        check("mid_gnt", 32'(if_gnt_o), 32'h1);
        reset = 1'b0;
        #1;
        check("mid_ctrl", 32'({if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, err_o, busy_o}), 32'h0);
        check("mid_rdata", rdata_o, 32'h0);
        check("mid_romaddr", rom_addr_o, BASE);
        drive(1'b1, 1'b1, 32'h0040_0004);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_gnt(got, n);
        check("post_rst_gnt_seen", 32'(got), 32'h1);
        check("post_rst_gnt_owner", 32'({if_gnt_o, dm_gnt_o}), 32'h2);
        push_exp(1'b0, 32'h0040_0008);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        repeat (4) @(negedge clk);

        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares the single combinational instruction ROM between two requesters: instruction fetch (IF, port 0) and data-side constant/literal reads (DM, port 1).
- Arbitrates one access at a time, range-checks the byte address against the text segment, drives the ROM address, and registers the returned word.
- Sits between the fetch/load-store logic and the existing ROM inside the memory system. The ROM keeps doing its own base subtraction and word indexing.

Parameters:
- DATA_WIDTH, 32, width of addresses and instruction/data words.
- MEMORY_DEPTH, 64, number of words in the ROM; used for the range check.
- BASE_ADDR, 32'h0040_0000, byte address of ROM word 0 (text segment base).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req_i  input  1  IF request; held high with if_addr_i stable until if_rvalid_o.
- if_addr_i  input  DATA_WIDTH  IF byte address.
- dm_req_i  input  1  DM request; same rules as IF.
- dm_addr_i  input  DATA_WIDTH  DM byte address.
- if_gnt_o  output  1  one-cycle pulse: IF request accepted.
- dm_gnt_o  output  1  one-cycle pulse: DM request accepted.
- if_rvalid_o  output  1  one-cycle pulse: rdata_o/err_o belong to IF.
- dm_rvalid_o  output  1  one-cycle pulse: rdata_o/err_o belong to DM.
- rdata_o  output  DATA_WIDTH  registered read word.
- err_o  output  1  access was out of range or misaligned; valid with an rvalid.
- busy_o  output  1  high in any state other than IDLE.
- rom_addr_o  output  DATA_WIDTH  byte address to the ROM Address_i.
- rom_data_i  input  DATA_WIDTH  ROM Instruction_o (combinational).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All gnt, rvalid, err and busy outputs are 0.
  - rdata_o = 0; rom_addr_o = BASE_ADDR.
  - last_owner = DM, so the first tie goes to IF.
- States: IDLE -> ACCESS -> RESP -> IDLE. Fixed cadence: 1 access per 3 cycles max.
- IDLE, cycle T:
  - If any request is high, select a winner and latch its address, owner and valid flag. Next state is ACCESS.
  - If no request is high, stay in IDLE.
- Winner selection, round-robin: single request wins; when both are high, the port that is not last_owner wins. last_owner updates on each grant.
- Address valid when all of the following hold:
  - addr[1:0] == 0;
  - addr >= BASE_ADDR;
  - ((addr - BASE_ADDR) >> 2) < MEMORY_DEPTH.
  - The comparison is done in DATA_WIDTH unsigned arithmetic, and addr < BASE_ADDR is checked first, so subtraction wrap is never used.
- ACCESS, cycle T+1:
  - gnt_o of the owner is high.
  - rom_addr_o = latched address if valid, else BASE_ADDR (no out-of-range ROM index).
  - At the end of the cycle: rdata_o <= valid ? rom_data_i : 0, and err_o <= !valid.
- RESP, cycle T+2:
  - The owner's rvalid_o is high for exactly 1 cycle, with rdata_o and err_o valid.
  - No arbitration happens in RESP. The requester drops req or changes its address for cycle T+3.
- rdata_o and err_o hold their values until the next ACCESS completes. err_o is meaningful only alongside an rvalid.
- Request dropped after grant: the access still completes and the rvalid pulse is still issued; the requester ignores it.
- Address changed while req is high before the grant: the value sampled in IDLE is the one used.
- Reset asserted mid-ACCESS or mid-RESP: the transaction is aborted and no rvalid is issued. After release, arbitration restarts with the IF tie priority.
- busy_o = 1 in ACCESS and RESP.
- rom_addr_o holds its last value in IDLE and RESP.

Optional Feature:
- Macro: ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, IF always wins when both requests are high. last_owner is not implemented.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Single IF read, valid address:
  - Stimulus: if_req_i=1, if_addr_i=32'h0040_0008, ROM word 2 = 32'h2009_0005.
  - Response: if_gnt_o pulses in cycle 1; if_rvalid_o pulses in cycle 2 with rdata_o=32'h2009_0005 and err_o=0; dm outputs stay 0.
- Both requests high continuously from reset, IF addr 32'h0040_0000, DM addr 32'h0040_0004:
  - Response: grants alternate IF, DM, IF, DM, with one rvalid every 3 cycles.
  - With ROM_ARB_FIXED_PRIO_EN defined: only IF is granted.
- Out-of-range and misaligned DM accesses:
  - dm_addr_i=32'h0040_0100 (word 64) gives dm_rvalid_o with err_o=1 and rdata_o=0.
  - 32'h003F_FFFC gives err_o=1.
  - 32'h0040_0002 gives err_o=1.
  - In all three cases rom_addr_o stays at 32'h0040_0000.
- Boundary word: dm_addr_i=32'h0040_00FC (word 63) -> err_o=0, rdata_o = ROM word 63.
- Reset mid-operation:
  - Stimulus: assert reset=0 during the ACCESS cycle of an IF read.
  - Response: all outputs go to 0 immediately and no if_rvalid_o is issued.
  - After release with both requests high, the first grant goes to IF.
- Request dropped after grant: if_req_i drops in cycle T+1 -> if_rvalid_o still pulses in T+2, and the arbiter returns to IDLE with busy_o=0 in T+3.
